// File: rtl/efm_bitstream_decoder_pkg.sv
// Shared types and constants for the EFM bitstream decoder: state encoding,
// window-length helper and the lock comparison tolerance.
package efm_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } dec_state_e;

  localparam int unsigned LOCK_TOL = 1;

  function automatic int unsigned window_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/efm_bitstream_decoder_if.sv
// Bundle of the decoder's run/bitstream inputs and recovered-word outputs.
// The slave modport faces the decoder; the master modport faces whatever drives it.
interface efm_bitstream_decoder_if #(
  parameter int P_DATA_WIDTH = 8
);
  logic                    i_enable;
  logic                    i_quantize;
  logic [P_DATA_WIDTH-1:0] o_dec_data;
  logic                    o_dec_valid;
  logic                    o_overflow;
  logic                    o_busy;
  logic                    o_locked;

  modport master (
    output i_enable,
    output i_quantize,
    input  o_dec_data,
    input  o_dec_valid,
    input  o_overflow,
    input  o_busy,
    input  o_locked
  );

  modport slave (
    input  i_enable,
    input  i_quantize,
    output o_dec_data,
    output o_dec_valid,
    output o_overflow,
    output o_busy,
    output o_locked
  );
endinterface

// File: rtl/efm_bitstream_decoder_window_acc.sv
// Accumulate-and-dump core: counts carries over 2^P_DATA_WIDTH samples and
// presents the saturated window total together with a dump strobe.
module efm_dec_window_acc
  import efm_dec_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    sampleEn_i,
  input  logic                    bit_i,
  output logic                    dump_o,
  output logic [P_DATA_WIDTH-1:0] dumpData_o,
  output logic                    dumpSat_o
);

  localparam int unsigned WIN_LEN = window_len(P_DATA_WIDTH);

  logic [P_DATA_WIDTH-1:0] winCnt_q, winCnt_d;
  logic [P_DATA_WIDTH:0]   acc_q, acc_d;
  logic [P_DATA_WIDTH:0]   total;

  // The extra accumulator bit only sets when every sample in the window was a carry.
  assign total      = acc_q + {{P_DATA_WIDTH{1'b0}}, bit_i};
  assign dump_o     = sampleEn_i && (winCnt_q == P_DATA_WIDTH'(WIN_LEN - 1));
  assign dumpSat_o  = total[P_DATA_WIDTH];
  assign dumpData_o = total[P_DATA_WIDTH] ? '1 : total[P_DATA_WIDTH-1:0];

  always_comb begin
    winCnt_d = winCnt_q;
    acc_d    = acc_q;
    if (!sampleEn_i || dump_o) begin
      winCnt_d = '0;
      acc_d    = '0;
    end else begin
      winCnt_d = winCnt_q + 1'b1;
      acc_d    = total;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      winCnt_q <= '0;
      acc_q    <= '0;
    end else begin
      winCnt_q <= winCnt_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/efm_bitstream_decoder.sv
// EFM bitstream decoder: recovers the fractional word from the carry stream.
// Optional lock detector enabled by defining EFM_DEC_LOCK_DET_EN.
module efm_bitstream_decoder
  import efm_dec_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_SETTLE     = 4,
  parameter int P_LOCK_CNT   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  efm_bitstream_decoder_if.slave  dec
);

  localparam int SW = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;

  if (P_SETTLE < 1 || P_LOCK_CNT < 1) begin : gBadParams
    $error("efm_bitstream_decoder: P_SETTLE and P_LOCK_CNT must be at least 1");
  end

  dec_state_e              state_q;
  logic [SW-1:0]           settle_q;
  logic [P_DATA_WIDTH-1:0] decData_q;
  logic                    decValid_q;
  logic                    overflow_q;
  logic                    busy_q;

  logic                    sampleEn;
  logic                    dump;
  logic [P_DATA_WIDTH-1:0] dumpData;
  logic                    dumpSat;

  // Dropping enable on the final sample suppresses the dump, so disable always wins.
  assign sampleEn = (state_q == ST_ACCUM) && dec.i_enable;

  efm_dec_window_acc #(
    .P_DATA_WIDTH(P_DATA_WIDTH)
  ) uWindowAcc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .sampleEn_i (sampleEn),
    .bit_i      (dec.i_quantize),
    .dump_o     (dump),
    .dumpData_o (dumpData),
    .dumpSat_o  (dumpSat)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      decData_q  <= '0;
      decValid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      decValid_q <= 1'b0;
      overflow_q <= 1'b0;
      if (!dec.i_enable) begin
        state_q  <= ST_IDLE;
        settle_q <= '0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            busy_q   <= 1'b1;
          end
          ST_SETTLE: begin
            busy_q <= 1'b1;
            if (settle_q == SW'(P_SETTLE - 1)) begin
              state_q <= ST_ACCUM;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          ST_ACCUM: begin
            busy_q <= 1'b1;
            if (dump) begin
              decData_q  <= dumpData;
              decValid_q <= 1'b1;
              overflow_q <= dumpSat;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dec.o_dec_data  = decData_q;
  assign dec.o_dec_valid = decValid_q;
  assign dec.o_overflow  = overflow_q;
  assign dec.o_busy      = busy_q;

`ifdef EFM_DEC_LOCK_DET_EN
  localparam int MW = $clog2(P_LOCK_CNT + 1);

  logic [P_DATA_WIDTH-1:0] prevData_q;
  logic                    havePrev_q;
  logic [MW-1:0]           matchCnt_q;
  logic                    locked_q;
  logic [P_DATA_WIDTH-1:0] absDiff;
  logic [MW-1:0]           matchNext;

  assign absDiff   = (dumpData >= prevData_q) ? (dumpData - prevData_q) : (prevData_q - dumpData);
  assign matchNext = (matchCnt_q == MW'(P_LOCK_CNT)) ? matchCnt_q : matchCnt_q + 1'b1;

  // The first window after entering ACCUM only seeds the comparison.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prevData_q <= '0;
      havePrev_q <= 1'b0;
      matchCnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (!sampleEn) begin
      havePrev_q <= 1'b0;
      matchCnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (dump) begin
      prevData_q <= dumpData;
      havePrev_q <= 1'b1;
      if (!havePrev_q) begin
        matchCnt_q <= '0;
        locked_q   <= (P_LOCK_CNT <= 1);
      end else if (absDiff <= P_DATA_WIDTH'(LOCK_TOL)) begin
        matchCnt_q <= matchNext;
        locked_q   <= (matchNext >= MW'(P_LOCK_CNT - 1));
      end else begin
        matchCnt_q <= '0;
        locked_q   <= 1'b0;
      end
    end
  end

  assign dec.o_locked = locked_q;
`else
  assign dec.o_locked = 1'b0;
`endif

endmodule

// File: tb/tb_efm_bitstream_decoder.sv
// Scoreboard bench for efm_bitstream_decoder: directed windows from a reference
// first-order EFM, expected results queued at stimulus time and checked by a monitor.
module tb_efm_bitstream_decoder;

  localparam int DW    = 8;
  localparam int SETTL = 4;
  localparam int WIN   = 256;
  localparam int LOCKN = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          ovf;
    logic          lck;
    int            cyc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  efm_bitstream_decoder_if #(.P_DATA_WIDTH(DW)) decIf ();

  efm_bitstream_decoder #(
    .P_DATA_WIDTH(DW),
    .P_SETTLE    (SETTL),
    .P_LOCK_CNT  (LOCKN)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .dec    (decIf.slave)
  );

  exp_t          expQ[$];
  int            cycleCnt    = 0;
  int            testsRun    = 0;
  int            testsFailed = 0;
  int            qMode       = 2;
  logic [DW-1:0] efmIn       = '0;
  logic [DW:0]   efmAcc      = '0;
  int            e0;
  int            lastEdge;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycleCnt++;
  end

  // Reference EFM: the carry out of an 8-bit phase accumulator, one sample per cycle.
  initial begin
    decIf.i_quantize = 1'b0;
    forever begin
      @(negedge clk);
      case (qMode)
        0: begin
          efmAcc = {1'b0, efmAcc[DW-1:0]} + {1'b0, efmIn};
          decIf.i_quantize = efmAcc[DW];
        end
        1:       decIf.i_quantize = 1'b1;
        default: decIf.i_quantize = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (decIf.o_dec_valid === 1'b1) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpected_valid: got valid at cycle %0d data=%02h, required no valid",
                   cycleCnt, decIf.o_dec_data);
        end else begin
          e = expQ.pop_front();
          if (decIf.o_dec_data !== e.data || decIf.o_overflow !== e.ovf ||
              decIf.o_locked !== e.lck || cycleCnt != e.cyc) begin
            testsFailed++;
            $display("[TB] FAIL window_result: got data=%02h ovf=%0b lck=%0b cyc=%0d, required data=%02h ovf=%0b lck=%0b cyc=%0d",
                     decIf.o_dec_data, decIf.o_overflow, decIf.o_locked, cycleCnt,
                     e.data, e.ovf, e.lck, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycleCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic enable, input int mode, input logic [DW-1:0] value);
    decIf.i_enable = enable;
    qMode          = mode;
    efmIn          = value;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic pushExp(input logic [DW-1:0] data, input logic ovf, input logic lck, input int cyc);
    exp_t e;
    e.data = data;
    e.ovf  = ovf;
    e.lck  = lck;
    e.cyc  = cyc;
    expQ.push_back(e);
  endtask

  task automatic waitEdge(input int n);
    while (cycleCnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic lockExp(input logic lockedWhenEnabled);
`ifdef EFM_DEC_LOCK_DET_EN
    return lockedWhenEnabled;
`else
    return lockedWhenEnabled & 1'b0;
`endif
  endfunction

  task automatic checkIdle(input string tag, input logic [DW-1:0] heldData);
    checkOutput({tag, "_busy"},   32'(decIf.o_busy),      32'd0);
    checkOutput({tag, "_data"},   32'(decIf.o_dec_data),  32'(heldData));
    checkOutput({tag, "_locked"}, 32'(decIf.o_locked),    32'd0);
  endtask

  initial begin
    applyStimulus(1'b0, 2, '0);
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data",   32'(decIf.o_dec_data),  32'd0);
    checkOutput("reset_valid",  32'(decIf.o_dec_valid), 32'd0);
    checkOutput("reset_ovf",    32'(decIf.o_overflow),  32'd0);
    checkOutput("reset_busy",   32'(decIf.o_busy),      32'd0);
    checkOutput("reset_locked", 32'(decIf.o_locked),    32'd0);
    rstN = 1'b1;
    waitEdge(cycleCnt + 2);

    // Four windows at 0x40 (lock rises on the fourth), then a 0x80 window breaks lock.
    e0 = cycleCnt + 1;
    applyStimulus(1'b1, 0, 8'h40);
    for (int k = 0; k < 4; k++) begin
      pushExp(8'h40, 1'b0, lockExp(k == 3), e0 + SETTL + WIN + WIN * k);
    end
    waitEdge(e0);
    checkOutput("settle_busy", 32'(decIf.o_busy), 32'd1);
    lastEdge = e0 + SETTL + WIN * 4;
    waitEdge(lastEdge);
    applyStimulus(1'b1, 0, 8'h80);
    pushExp(8'h80, 1'b0, 1'b0, lastEdge + WIN);
    lastEdge = lastEdge + WIN;
    waitEdge(lastEdge);

    // Abort at sample 100 of the following window.
    waitEdge(lastEdge + 100);
    applyStimulus(1'b0, 0, 8'h80);
    waitEdge(lastEdge + 101);
    checkIdle("abort", 8'h80);
    waitEdge(cycleCnt + 5);
    checkOutput("abort_hold_data", 32'(decIf.o_dec_data), 32'h80);

    // Re-enable with a constant-one stream (saturation), then a constant-zero window.
    e0 = cycleCnt + 1;
    applyStimulus(1'b1, 1, '0);
    pushExp(8'hFF, 1'b1, 1'b0, e0 + SETTL + WIN);
    lastEdge = e0 + SETTL + WIN;
    waitEdge(lastEdge);
    applyStimulus(1'b1, 2, '0);
    pushExp(8'h00, 1'b0, 1'b0, lastEdge + WIN);
    lastEdge = lastEdge + WIN;
    waitEdge(lastEdge);
    checkOutput("zero_window_data", 32'(decIf.o_dec_data), 32'h00);

    // Disable coincides with sample 255 of an all-ones window: no result may appear.
    applyStimulus(1'b1, 1, '0);
    waitEdge(lastEdge + 255);
    applyStimulus(1'b0, 1, '0);
    waitEdge(lastEdge + 256);
    checkIdle("boundary", 8'h00);
    waitEdge(cycleCnt + 3);
    checkOutput("boundary_hold_data", 32'(decIf.o_dec_data), 32'h00);

    // One 0x40 window, then asynchronous reset mid-window.
    e0 = cycleCnt + 1;
    applyStimulus(1'b1, 0, 8'h40);
    pushExp(8'h40, 1'b0, 1'b0, e0 + SETTL + WIN);
    lastEdge = e0 + SETTL + WIN;
    waitEdge(lastEdge + 50);
    checkOutput("pre_reset_busy", 32'(decIf.o_busy), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_data",  32'(decIf.o_dec_data),  32'd0);
    checkOutput("async_reset_busy",  32'(decIf.o_busy),      32'd0);
    checkOutput("async_reset_valid", 32'(decIf.o_dec_valid), 32'd0);
    waitEdge(cycleCnt + 3);
    rstN = 1'b1;
    e0 = cycleCnt + 1;
    pushExp(8'h40, 1'b0, 1'b0, e0 + SETTL + WIN);
    waitEdge(e0 + SETTL + WIN);
    waitEdge(cycleCnt + 3);
    applyStimulus(1'b0, 2, '0);
    waitEdge(cycleCnt + 5);

    checkOutput("pending_expectations", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
